// File: rtl/sweep_stim_capture.sv
// Exhaustive input sweep engine: drives every IN_W-bit vector, samples the DUT and streams indexed records.
// Optional 16-bit output signature when SWEEP_SIGNATURE_EN is defined.
module sweep_stim_capture #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 1,
  parameter int PASSES = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             gray_mode,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  vec,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_index,
  output logic [IN_W-1:0]  rec_vec,
  output logic [OUT_W-1:0] rec_out
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]      sig
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PASSES * (1 << IN_W) - 1);
  localparam logic [7:0]       SETTLE_END = 8'(SETTLE - 1);

  state_t           r_state, w_next;
  logic             r_gray;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_settle;
  logic [IN_W-1:0]  r_vec;
  logic [CNT_W-1:0] r_rec_index;
  logic [IN_W-1:0]  r_rec_vec;
  logic [OUT_W-1:0] r_rec_out;

  logic             w_fire;
  logic             w_last;
  logic             w_settle_end;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IN_W-1:0]  w_vec_next;

  function automatic logic [IN_W-1:0] map_vec(input logic [IN_W-1:0] b, input logic g);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  assign w_fire       = (r_state == S_EMIT) && rec_ready;
  assign w_last       = (r_cnt == LAST_CNT);
  assign w_settle_end = (r_settle == SETTLE_END);
  assign w_cnt_next   = r_cnt + 1'b1;
  // Vector for the next record is prepared on the fire edge so DRIVE starts with it already applied.
  assign w_vec_next   = map_vec(w_cnt_next[IN_W-1:0], r_gray);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_next = S_DRIVE;
      S_DRIVE: if (w_settle_end) w_next = S_EMIT;
      S_EMIT:  if (w_fire)       w_next = w_last ? S_DONE : S_DRIVE;
      S_DONE:                    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gray      <= 1'b0;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_vec       <= '0;
      r_rec_index <= '0;
      r_rec_vec   <= '0;
      r_rec_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_gray   <= gray_mode;
          r_cnt    <= '0;
          r_settle <= '0;
          r_vec    <= '0;
        end
        S_DRIVE: if (w_settle_end) begin
          r_settle    <= '0;
          r_rec_out   <= dut_out;
          r_rec_vec   <= r_vec;
          r_rec_index <= r_cnt;
        end else begin
          r_settle <= r_settle + 8'd1;
        end
        S_EMIT: if (w_fire && !w_last) begin
          r_cnt <= w_cnt_next;
          r_vec <= w_vec_next;
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  localparam int SIG_W = (OUT_W < 16) ? OUT_W : 16;

  logic [15:0] r_sig;
  logic [15:0] w_sig_in;

  always_comb begin
    w_sig_in              = '0;
    w_sig_in[SIG_W-1:0]   = r_rec_out[SIG_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     r_sig <= '0;
    else if (r_state == S_IDLE && start) r_sig <= '0;
    else if (w_fire)                  r_sig <= {r_sig[14:0], r_sig[15]} ^ w_sig_in;
  end

  assign sig = r_sig;
`endif

  assign busy      = (r_state == S_DRIVE) || (r_state == S_EMIT);
  assign done      = (r_state == S_DONE);
  assign rec_valid = (r_state == S_EMIT);
  assign vec       = r_vec;
  assign rec_index = r_rec_index;
  assign rec_vec   = r_rec_vec;
  assign rec_out   = r_rec_out;

endmodule

// File: tb/tb_sweep_stim_capture.sv
// Self-checking bench for sweep_stim_capture: record stream compared against a sweep-order model.
// Signature checks are active when SWEEP_SIGNATURE_EN is defined.
module tb_sweep_stim_capture;

  localparam int IN_W   = 4;
  localparam int OUT_W  = 8;
  localparam int PASSES = 2;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;
  localparam int TOTAL  = PASSES << IN_W;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             gray_mode = 1'b0;
  logic             busy, done, rec_valid;
  logic             rec_ready = 1'b1;
  logic [IN_W-1:0]  vec, rec_vec;
  logic [OUT_W-1:0] dut_out, rec_out;
  logic [CNT_W-1:0] rec_index;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0]      sig;
`endif

  sweep_stim_capture #(
    .IN_W(IN_W), .OUT_W(OUT_W), .PASSES(PASSES), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .gray_mode(gray_mode),
    .busy(busy), .done(done), .vec(vec), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_index(rec_index),
    .rec_vec(rec_vec), .rec_out(rec_out)
`ifdef SWEEP_SIGNATURE_EN
    , .sig(sig)
`endif
  );

  always #5 clock = ~clock;

  // Combinational function under characterisation.
  assign dut_out = 8'({4'b0000, vec} * 8'd13 + 8'd7);

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int              m_k = 0;
  logic            m_gray = 1'b0;
  int              m_sig = 0;
  logic            m_held = 1'b0;
  logic            m_have_prev = 1'b0;
  logic [IN_W-1:0] m_prev_vec = '0;
  logic [CNT_W-1:0] h_index;
  logic [IN_W-1:0]  h_vec;
  logic [OUT_W-1:0] h_out;
  logic            prev_done = 1'b0;
  int              done_cnt = 0;
  int              busy_cycles = 0;
  int              stall_cnt = 0;
  logic [IN_W-1:0] vec_log [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] exp_vec(input int k);
    int b;
    b = k % (1 << IN_W);
    if (m_gray) b = b ^ (b >> 1);
    return IN_W'(b);
  endfunction

  function automatic logic [OUT_W-1:0] f_model(input logic [IN_W-1:0] v);
    return OUT_W'((int'(v) * 13 + 7) % 256);
  endfunction

  // Compare process: every cycle out of reset.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_held    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy) check("vec_driven", 64'(vec), 64'(exp_vec(m_k)));
      if (rec_valid) begin
        if (m_held) begin
          check("stall_index", 64'(rec_index), 64'(h_index));
          check("stall_vec", 64'(rec_vec), 64'(h_vec));
          check("stall_out", 64'(rec_out), 64'(h_out));
        end
        if (rec_ready) begin
          check("rec_index", 64'(rec_index), 64'(m_k));
          check("rec_vec", 64'(rec_vec), 64'(exp_vec(m_k)));
          check("rec_out", 64'(rec_out), 64'(f_model(exp_vec(m_k))));
          if (m_gray && m_have_prev)
            check("gray_one_bit", 64'($countones(rec_vec ^ m_prev_vec)), 64'd1);
`ifdef SWEEP_SIGNATURE_EN
          check("sig_before_fire", 64'(sig), 64'(m_sig));
          m_sig = (((m_sig << 1) | (m_sig >> 15)) & 16'hFFFF) ^ int'(f_model(exp_vec(m_k)));
`endif
          if (m_k < 64) vec_log[m_k] = rec_vec;
          m_prev_vec  = rec_vec;
          m_have_prev = 1'b1;
          m_k++;
          m_held = 1'b0;
        end else begin
          stall_cnt++;
          m_held  = 1'b1;
          h_index = rec_index;
          h_vec   = rec_vec;
          h_out   = rec_out;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_all_records", 64'(m_k), 64'(TOTAL));
        check("done_busy_low", 64'(busy), 64'd0);
        check("done_valid_low", 64'(rec_valid), 64'd0);
        check("done_vec_hold", 64'(vec), 64'(exp_vec(TOTAL - 1)));
        if (prev_done) begin
          n_tests++; n_fail++;
          $display("FAIL done_one_cycle: done high on two consecutive cycles");
        end
      end
      prev_done = done;
      if (busy) busy_cycles++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valid"}, 64'(rec_valid), 64'd0);
    check({tag, "_vec"}, 64'(vec), 64'd0);
    check({tag, "_index"}, 64'(rec_index), 64'd0);
    check({tag, "_rvec"}, 64'(rec_vec), 64'd0);
    check({tag, "_rout"}, 64'(rec_out), 64'd0);
`ifdef SWEEP_SIGNATURE_EN
    check({tag, "_sig"}, 64'(sig), 64'd0);
`endif
  endtask

  task automatic start_sweep(input logic g);
    @(posedge clock); #1;
    start       = 1'b1;
    gray_mode   = g;
    m_k         = 0;
    m_gray      = g;
    m_sig       = 0;
    m_have_prev = 1'b0;
    busy_cycles = 0;
    stall_cnt   = 0;
  endtask

  // mode 0: ready high, 1: random ready, 2: five-cycle stall at index 1
  task automatic wait_done(input int mode, input bit poke);
    int  d0;
    int  stall_left;
    bit  poked;
    bit  seen;
    d0 = done_cnt; stall_left = 5; poked = 0; seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clock); #1;
      if (poke && !poked && busy && m_k == 3) begin
        start = 1'b1; gray_mode = ~m_gray; poked = 1;
      end else begin
        start = 1'b0;
      end
      if (mode == 1) begin
        rec_ready = ($urandom_range(0, 3) != 0);
        gray_mode = 1'($urandom);
      end else if (mode == 2 && rec_valid && m_k == 1 && stall_left > 0) begin
        rec_ready = 1'b0; stall_left--;
      end else begin
        rec_ready = 1'b1;
      end
      if (done_cnt != d0) seen = 1;
    end
    start = 1'b0; rec_ready = 1'b1;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL sweep_timeout: no done within cycle budget, records=%0d", m_k);
    end
    repeat (4) @(posedge clock);
    #1;
    check("single_done", 64'(done_cnt - d0), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(rec_valid), 64'd0);
  endtask

  initial begin
    int d0;
    bit hit;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Binary sweep, ready always high
    start_sweep(1'b0);
    wait_done(0, 0);
    check("bin_busy_cycles", 64'(busy_cycles), 64'd96);
    check("bin_vec_at_15", 64'(vec_log[15]), 64'd15);
    check("bin_vec_at_16", 64'(vec_log[16]), 64'd0);
    check("bin_vec_at_31", 64'(vec_log[31]), 64'd15);
`ifdef SWEEP_SIGNATURE_EN
    check("sig_final_bin", 64'(sig), 64'(m_sig));
`endif

    // Gray sweep
    start_sweep(1'b1);
    wait_done(0, 0);
    begin
      logic [IN_W-1:0] gray_ref [0:7];
      gray_ref = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
      for (int i = 0; i < 8; i++) check("gray_order", 64'(vec_log[i]), 64'(gray_ref[i]));
    end

    // Backpressure at index 1
    start_sweep(1'b0);
    wait_done(2, 0);
    check("stall_cycles", 64'(stall_cnt), 64'd5);

    // Random ready, random gray_mode wiggle, ignored start at index 3
    for (int r = 0; r < 3; r++) begin
      start_sweep(1'($urandom));
      wait_done(1, (r == 0));
    end

    // Reset mid-sweep at index 7
    start_sweep(1'b1);
    hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (m_k == 7) hit = 1;
    end
    if (!hit) begin
      n_tests++; n_fail++;
      $display("FAIL reset_reach_index7: index 7 not reached, records=%0d", m_k);
    end
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clock);
    #1;
    check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    reset_n = 1'b1;
    start_sweep(1'b0);
    wait_done(0, 0);
    check("restart_vec0", 64'(vec_log[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sweep_stim_capture.md
Name: sweep_stim_capture

Overview:
- Synthesizable exhaustive-sweep engine for characterising combinational functions.
- Drives every IN_W-bit input vector to a DUT, waits a settle window, samples the DUT output and emits one indexed record per vector over a valid/ready stream.
- Generalises the fixed 16-input, 1-output, 2-pass bench sweep: parametrised width, pass count and settle time, plus binary or Gray ordering and backpressure.
- Sits between the DUT and a record sink (CSV logger or checker).

Parameters:
- IN_W, 16, DUT input vector width (1..24).
- OUT_W, 1, DUT output width (1..32).
- PASSES, 2, number of full sweeps per start (1..4).
- SETTLE, 1, cycles vector held before sampling (1..255).
- CNT_W, 18, record index width; must be >= IN_W + clog2(PASSES).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- gray_mode  in  1  1 = Gray-code ordering; latched at start.
- busy  out  1  high from the cycle after start acceptance until DONE.
- done  out  1  one-cycle pulse when the final record is accepted.
- vec  out  IN_W  vector driven to the DUT.
- dut_out  in  OUT_W  DUT response.
- rec_valid  out  1  record available.
- rec_ready  in  1  sink accepts the record.
- rec_index  out  CNT_W  global record number, starting at 0.
- rec_vec  out  IN_W  vector the record was sampled under.
- rec_out  out  OUT_W  sampled dut_out.
- sig  out  16  output signature (only with SWEEP_SIGNATURE_EN).

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0, including vec, rec_* and sig.
- State IDLE
  - start=1 latches gray_mode.
  - Clears the counter and settle counter.
  - Next cycle: DRIVE with vec = map(0) and busy=1.
- State DRIVE
  - vec = map(cnt[IN_W-1:0]), where map is identity in binary mode and b ^ (b>>1) in Gray mode.
  - The settle counter counts SETTLE cycles; on the last one, rec_out <= dut_out, rec_vec <= vec, rec_index <= cnt.
  - Next: EMIT with rec_valid=1.
- State EMIT
  - rec_valid held; rec_* stable until the handshake.
  - Fire = rec_valid & rec_ready.
  - On fire with cnt = PASSES*2^IN_W - 1: DONE.
  - On any other fire: cnt+1, then DRIVE.
  - vec stays unchanged while EMIT stalls.
- State DONE: one cycle; done=1, busy=0, rec_valid=0; next IDLE. vec holds its last value.
- Wrap-around: the vector is cnt modulo 2^IN_W, so all-ones returns to 0 at each pass boundary while rec_index keeps incrementing.
- Throughput: with rec_ready held high, one record per SETTLE+1 cycles.
- start outside IDLE is ignored. gray_mode changes mid-sweep are ignored.
- Reset mid-sweep aborts immediately: no done pulse, rec_valid drops asynchronously.

Optional Feature:
- Macro name: SWEEP_SIGNATURE_EN.
- With the macro defined:
  - 16-bit sig is cleared on start acceptance.
  - On each fire: sig <= {sig[14:0], sig[15]} ^ zero-extend(rec_out[min(OUT_W,16)-1:0]).
  - sig holds after DONE until the next start.
- Without the macro: no sig port and no signature logic.

Test Plan:
- Binary sweep, IN_W=4, PASSES=2, SETTLE=1, rec_ready=1, DUT = identity on vec[0] → 32 records, rec_index 0..31, rec_vec 0..15 twice (index 16 → vec 0), done pulses once, 2 cycles per record.
- Gray sweep, IN_W=3, gray_mode=1 → rec_vec sequence 0,1,3,2,6,7,5,4; consecutive vectors differ in exactly one bit.
- Backpressure, IN_W=2, rec_ready low 5 cycles at index 1 → rec_valid high and rec_index/rec_vec/rec_out stable for all 5 cycles, no record lost or duplicated, final count 4*PASSES.
- Reset: pull reset_n low at index 7 → all outputs 0 in the same cycle, no done; a fresh start restarts at index 0.
- start pulsed at index 3 while busy → ignored, sweep completes normally with one done.
- SWEEP_SIGNATURE_EN, IN_W=2, PASSES=1, dut_out = vec[0] → records out 0,1,0,1 give sig 0x0000, 0x0001, 0x0002, 0x0005; final sig = 0x0005.
